// File: rtl/flash_audio_pkg.sv
// Shared types and constants for the flash-sample audio player:
// FSM states, keyboard command codes and the default lane geometry.
package flash_audio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_REQ       = 2'd1,
      ST_WAIT_DATA = 2'd2,
      ST_PLAY      = 2'd3
   } state_t;

   // Lower-case command letters; OR-ing in CASE_BIT folds upper case onto them.
   localparam logic [7:0] CASE_BIT    = 8'h20;
   localparam logic [7:0] KEY_PLAY    = 8'h65;  // 'e'
   localparam logic [7:0] KEY_PAUSE   = 8'h64;  // 'd'
   localparam logic [7:0] KEY_FWD     = 8'h66;  // 'f'
   localparam logic [7:0] KEY_BWD     = 8'h62;  // 'b'
   localparam logic [7:0] KEY_RESTART = 8'h72;  // 'r'

   function automatic int lane_idx_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_SAMPLE_W = 8;
   localparam int LANES        = DEF_DATA_W / DEF_SAMPLE_W;
   localparam int LANE_W       = lane_idx_w(LANES);

   typedef struct packed {
      logic play;
      logic pause;
      logic fwd;
      logic bwd;
      logic restart;
   } key_cmd_t;

endpackage

// File: rtl/flash_audio_player_key_decode.sv
// ASCII keyboard code to one-hot player command, qualified by key_valid.
module player_key_decode
   import flash_audio_pkg::*;
(
   input  logic       key_valid,
   input  logic [7:0] key_ascii,
   output key_cmd_t   cmd
);

   logic [7:0] key_lc;

   // Only letters are folded usefully; any other code folds onto a non-command value.
   assign key_lc = key_ascii | CASE_BIT;

   always_comb begin
      cmd = '0;
      if (key_valid) begin
         case (key_lc)
            KEY_PLAY:    cmd.play    = 1'b1;
            KEY_PAUSE:   cmd.pause   = 1'b1;
            KEY_FWD:     cmd.fwd     = 1'b1;
            KEY_BWD:     cmd.bwd     = 1'b1;
            KEY_RESTART: cmd.restart = 1'b1;
            default:     cmd         = '0;
         endcase
      end
   end

endmodule

// File: rtl/flash_audio_player.sv
// Flash-sample playback controller: fetches packed words over Avalon-MM and
// unpacks one sample per sample_tick, steered by keyboard commands.
module flash_audio_player
   import flash_audio_pkg::*;
#(
   parameter int                ADDR_W     = 23,
   parameter int                DATA_W     = 32,
   parameter int                SAMPLE_W   = 8,
   parameter logic [ADDR_W-1:0] START_ADDR = '0,
   parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'('h7FFFF)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                sample_tick,
   input  logic                key_valid,
   input  logic [7:0]          key_ascii,
   output logic                flash_mem_read,
   output logic [ADDR_W-1:0]   flash_mem_address,
   input  logic                flash_mem_waitrequest,
   input  logic [DATA_W-1:0]   flash_mem_readdata,
   input  logic                flash_mem_readdatavalid,
   output logic [SAMPLE_W-1:0] audio_data,
   output logic                audio_valid,
   output logic                playing,
   output logic                direction,
   output logic                underrun
);

   localparam int                 N_LANES   = DATA_W / SAMPLE_W;
   localparam int                 N_LANE_W  = lane_idx_w(N_LANES);
   localparam logic [N_LANE_W-1:0] LAST_LANE = N_LANE_W'(N_LANES - 1);

   key_cmd_t            cmd;
   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr_nxt, restart_addr;
   logic [DATA_W-1:0]   word;
   logic                word_load;
   logic                word_valid, word_valid_nxt;
   logic [N_LANE_W-1:0] lane, lane_nxt;
   logic                discard, discard_nxt;
   logic                restart_pend, restart_pend_nxt;
   logic                playing_nxt, direction_nxt;
   logic [SAMPLE_W-1:0] audio_nxt, cur_sample;
   logic                audio_valid_nxt, underrun_nxt;
   logic                last_lane;

   player_key_decode u_key_decode (
      .key_valid (key_valid),
      .key_ascii (key_ascii),
      .cmd       (cmd)
   );

   function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a,
                                                   input logic              back);
      if (back) return (a == START_ADDR) ? END_ADDR : a - ADDR_W'(1);
      else      return (a == END_ADDR) ? START_ADDR : a + ADDR_W'(1);
   endfunction

   assign flash_mem_read = (state == ST_REQ);
   assign cur_sample     = word[int'(lane)*SAMPLE_W +: SAMPLE_W];
   assign last_lane      = direction ? (lane == '0) : (lane == LAST_LANE);

   // Commands land in the registers at this edge; everything else sees the
   // pre-command playing/direction, so a same-cycle tick uses the old mode.
   assign playing_nxt   = cmd.play ? 1'b1 : (cmd.pause ? 1'b0 : playing);
   assign direction_nxt = cmd.fwd  ? 1'b0 : (cmd.bwd   ? 1'b1 : direction);
   assign restart_addr  = direction_nxt ? END_ADDR : START_ADDR;

   always_comb begin
      // NOTE: every combinational output gets a default first; a missed branch would infer a latch.
      state_nxt        = state;
      addr_nxt         = flash_mem_address;
      word_load        = 1'b0;
      word_valid_nxt   = word_valid;
      lane_nxt         = lane;
      discard_nxt      = discard;
      restart_pend_nxt = restart_pend;
      audio_nxt        = audio_data;
      audio_valid_nxt  = 1'b0;
      underrun_nxt     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (cmd.restart) begin
               addr_nxt       = restart_addr;
               word_valid_nxt = 1'b0;
            end
            if (playing)
               state_nxt = (word_valid && !cmd.restart) ? ST_PLAY : ST_REQ;
         end

         ST_REQ: begin
            underrun_nxt = sample_tick && playing;
            // The address must stay put while the request is stalled, so a
            // restart is only applied once the slave accepts.
            if (!flash_mem_waitrequest) begin
               state_nxt = ST_WAIT_DATA;
               if (cmd.restart || restart_pend) begin
                  addr_nxt         = restart_addr;
                  discard_nxt      = 1'b1;
                  restart_pend_nxt = 1'b0;
               end
            end else if (cmd.restart) begin
               restart_pend_nxt = 1'b1;
            end
         end

         ST_WAIT_DATA: begin
            underrun_nxt = sample_tick && playing;
            if (cmd.restart) begin
               addr_nxt    = restart_addr;
               discard_nxt = 1'b1;
            end
            if (flash_mem_readdatavalid) begin
               if (discard || cmd.restart) begin
                  discard_nxt = 1'b0;
                  state_nxt   = playing ? ST_REQ : ST_IDLE;
               end else begin
                  word_load      = 1'b1;
                  word_valid_nxt = 1'b1;
                  lane_nxt       = direction_nxt ? LAST_LANE : '0;
                  state_nxt      = playing ? ST_PLAY : ST_IDLE;
               end
            end
         end

         ST_PLAY: begin
            if (!playing) begin
               state_nxt = ST_IDLE;
            end else if (sample_tick) begin
               audio_nxt       = cur_sample;
               audio_valid_nxt = 1'b1;
               if (last_lane) begin
                  addr_nxt       = addr_step(flash_mem_address, direction);
                  word_valid_nxt = 1'b0;
                  state_nxt      = ST_REQ;
               end else begin
                  lane_nxt = direction ? lane - N_LANE_W'(1) : lane + N_LANE_W'(1);
               end
            end
            if (cmd.restart) begin
               addr_nxt       = restart_addr;
               word_valid_nxt = 1'b0;
               state_nxt      = playing ? ST_REQ : ST_IDLE;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= ST_IDLE;
         flash_mem_address <= START_ADDR;
         word_valid        <= 1'b0;
         lane              <= '0;
         discard           <= 1'b0;
         restart_pend      <= 1'b0;
         playing           <= 1'b0;
         direction         <= 1'b0;
         audio_data        <= '0;
         audio_valid       <= 1'b0;
         underrun          <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         state             <= state_nxt;
         flash_mem_address <= addr_nxt;
         word_valid        <= word_valid_nxt;
         lane              <= lane_nxt;
         discard           <= discard_nxt;
         restart_pend      <= restart_pend_nxt;
         playing           <= playing_nxt;
         direction         <= direction_nxt;
         audio_data        <= audio_nxt;
         audio_valid       <= audio_valid_nxt;
         underrun          <= underrun_nxt;
      end
   end

   // NOTE: the word buffer is deliberately not reset; word_valid qualifies its contents.
   always_ff @(posedge clk) begin
      if (word_load) word <= flash_mem_readdata;
   end

endmodule

// File: tb/tb_flash_audio_player.sv
// Directed bench for flash_audio_player with a small Avalon-MM flash responder
// and a scoreboard queue of expected samples.
module tb_flash_audio_player;

   localparam int ADDR_W   = 23;
   localparam int DATA_W   = 32;
   localparam int SAMPLE_W = 8;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                sample_tick = 1'b0;
   logic                key_valid = 1'b0;
   logic [7:0]          key_ascii = 8'h00;
   logic                flash_mem_read;
   logic [ADDR_W-1:0]   flash_mem_address;
   logic                flash_mem_waitrequest = 1'b0;
   logic [DATA_W-1:0]   flash_mem_readdata = '0;
   logic                flash_mem_readdatavalid = 1'b0;
   logic [SAMPLE_W-1:0] audio_data;
   logic                audio_valid, playing, direction, underrun;

   flash_audio_player #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .SAMPLE_W   (SAMPLE_W),
      .START_ADDR (23'd0),
      .END_ADDR   (23'd3)
   ) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .sample_tick             (sample_tick),
      .key_valid               (key_valid),
      .key_ascii               (key_ascii),
      .flash_mem_read          (flash_mem_read),
      .flash_mem_address       (flash_mem_address),
      .flash_mem_waitrequest   (flash_mem_waitrequest),
      .flash_mem_readdata      (flash_mem_readdata),
      .flash_mem_readdatavalid (flash_mem_readdatavalid),
      .audio_data              (audio_data),
      .audio_valid             (audio_valid),
      .playing                 (playing),
      .direction               (direction),
      .underrun                (underrun)
   );

   always #5 clk = ~clk;

   // Flash responder: configurable stall per request and read latency.
   logic [31:0]       mem [4];
   int                wait_cfg   = 2;
   int                data_delay = 1;
   int                wait_left  = 0;
   int                data_cnt   = 0;
   int                read_cycles = 0;
   int                acc_wr     = 0;
   logic [ADDR_W-1:0] data_addr  = '0;
   logic [ADDR_W-1:0] acc_log [256];

   always @(negedge clk) begin
      flash_mem_readdatavalid = 1'b0;
      if (data_cnt > 0) begin
         data_cnt = data_cnt - 1;
         if (data_cnt == 0) begin
            flash_mem_readdatavalid = 1'b1;
            flash_mem_readdata      = mem[data_addr[1:0]];
         end
      end
      flash_mem_waitrequest = 1'b0;
      if (reset_n && flash_mem_read) begin
         read_cycles = read_cycles + 1;
         if (wait_left > 0) begin
            flash_mem_waitrequest = 1'b1;
            wait_left = wait_left - 1;
         end else begin
            acc_log[acc_wr % 256] = flash_mem_address;
            acc_wr    = acc_wr + 1;
            data_addr = flash_mem_address;
            data_cnt  = data_delay;
         end
      end else begin
         wait_left = wait_cfg;
      end
   end

   int                  checks = 0;
   int                  errors = 0;
   int                  acc_rd = 0;
   logic [SAMPLE_W-1:0] exp_q [$];
   logic [SAMPLE_W-1:0] last_audio = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic send_key(input logic [7:0] c);
      key_valid = 1'b1;
      key_ascii = c;
      step();
      key_valid = 1'b0;
      key_ascii = 8'h00;
   endtask

   task automatic tick_play();
      logic [SAMPLE_W-1:0] e;
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      e = exp_q.pop_front();
      check("audio_valid", {63'd0, audio_valid}, 64'd1);
      check("audio_data", {56'd0, audio_data}, {56'd0, e});
      last_audio = e;
   endtask

   task automatic tick_silent(input string tag);
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      check({tag, "_valid"}, {63'd0, audio_valid}, 64'd0);
      check({tag, "_underrun"}, {63'd0, underrun}, 64'd0);
   endtask

   task automatic play_word(input logic [31:0] w, input bit back);
      for (int i = 0; i < 4; i++) begin
         int l;
         l = back ? 3 - i : i;
         exp_q.push_back(w[8*l +: 8]);
      end
      repeat (4) tick_play();
   endtask

   task automatic wait_accept(input logic [ADDR_W-1:0] a);
      int n;
      n = 0;
      while (acc_wr == acc_rd && n < 200) begin
         step();
         n++;
      end
      if (acc_wr == acc_rd) begin
         check("accept_timeout", 64'd0, 64'd1);
      end else begin
         check("read_addr", {41'd0, acc_log[acc_rd % 256]}, {41'd0, a});
         acc_rd++;
      end
   endtask

   task automatic wait_rdv();
      int n;
      n = 0;
      while (!flash_mem_readdatavalid && n < 200) begin
         step();
         n++;
      end
      check("rdv_timeout", {63'd0, flash_mem_readdatavalid}, 64'd1);
   endtask

   task automatic expect_read(input logic [ADDR_W-1:0] a);
      wait_accept(a);
      wait_rdv();
      step();
   endtask

   initial begin
      int                  rc;
      logic [SAMPLE_W-1:0] hold;
      mem[0] = 32'h44332211;
      mem[1] = 32'h88776655;
      mem[2] = 32'h1F2E3D4C;
      mem[3] = 32'hDDCCBBAA;

      // Reset values
      repeat (2) step();
      check("rst_read", {63'd0, flash_mem_read}, 64'd0);
      check("rst_addr", {41'd0, flash_mem_address}, 64'd0);
      check("rst_audio", {56'd0, audio_data}, 64'd0);
      check("rst_valid", {63'd0, audio_valid}, 64'd0);
      check("rst_playing", {63'd0, playing}, 64'd0);
      check("rst_direction", {63'd0, direction}, 64'd0);
      check("rst_underrun", {63'd0, underrun}, 64'd0);
      reset_n = 1'b1;
      step();

      // Play with a two-cycle stall on the first read
      send_key(8'h65);
      check("playing_on", {63'd0, playing}, 64'd1);
      step();
      check("first_read", {63'd0, flash_mem_read}, 64'd1);
      wait_accept(23'd0);
      check("read_hold_cycles", 64'(read_cycles), 64'd3);
      wait_cfg = 0;
      wait_rdv();
      step();
      play_word(mem[0], 1'b0);
      check("next_read_1cyc", {63'd0, flash_mem_read}, 64'd1);
      check("next_read_addr", {41'd0, flash_mem_address}, 64'd1);
      expect_read(23'd1);

      // Backward from the end, wrapping 0 -> 3
      send_key(8'h42);
      check("direction_bwd", {63'd0, direction}, 64'd1);
      send_key(8'h52);
      send_key(8'h45);
      expect_read(23'd3);
      play_word(mem[3], 1'b1);
      expect_read(23'd2);
      play_word(mem[2], 1'b1);
      expect_read(23'd1);
      play_word(mem[1], 1'b1);
      expect_read(23'd0);
      play_word(mem[0], 1'b1);
      expect_read(23'd3);

      // Forward over all four words, wrapping 3 -> 0
      send_key(8'h66);
      send_key(8'h72);
      expect_read(23'd0);
      for (int a = 0; a < 4; a++) begin
         play_word(mem[a], 1'b0);
         expect_read(23'((a + 1) % 4));
      end

      // Pause mid-word, resume from the same sample with no new read
      rc = read_cycles;
      exp_q.push_back(8'h11);
      tick_play();
      exp_q.push_back(8'h22);
      tick_play();
      send_key(8'h44);
      check("playing_off", {63'd0, playing}, 64'd0);
      repeat (3) tick_silent("paused");
      send_key(8'h45);
      step();
      exp_q.push_back(8'h33);
      tick_play();
      check("no_read_on_resume", 64'(read_cycles), 64'(rc));

      // Restart during WAIT_DATA discards the returned word
      exp_q.push_back(8'h44);
      tick_play();
      expect_read(23'd1);
      data_delay = 4;
      play_word(mem[1], 1'b0);
      wait_accept(23'd2);
      data_delay = 1;
      step();
      check("wait_read_low", {63'd0, flash_mem_read}, 64'd0);
      send_key(8'h72);
      check("restart_addr", {41'd0, flash_mem_address}, 64'd0);
      expect_read(23'd0);
      exp_q.push_back(8'h11);
      tick_play();

      // Tick while the read is stalled
      wait_cfg = 50;
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h44);
      repeat (3) tick_play();
      check("req_read", {63'd0, flash_mem_read}, 64'd1);
      check("req_addr", {41'd0, flash_mem_address}, 64'd1);
      hold = last_audio;
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      check("underrun_pulse", {63'd0, underrun}, 64'd1);
      check("underrun_valid", {63'd0, audio_valid}, 64'd0);
      check("underrun_hold", {56'd0, audio_data}, {56'd0, hold});
      step();
      check("underrun_one_cycle", {63'd0, underrun}, 64'd0);

      // Asynchronous reset in the middle of a stalled request
      check("pre_reset_read", {63'd0, flash_mem_read}, 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_read", {63'd0, flash_mem_read}, 64'd0);
      check("async_rst_addr", {41'd0, flash_mem_address}, 64'd0);
      check("async_rst_playing", {63'd0, playing}, 64'd0);
      step();
      reset_n = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
